// File: rtl/rijndael_pkg.sv
// Shared Rijndael helpers: state-byte type, ShiftRows offset table and the
// InvShiftRows read-address function used by the byte-serial stage.
package rijndael_pkg;

    typedef logic [7:0] byte_t;

    // Row offsets are {0,1,2,3} for 4- and 6-column states, {0,1,3,4} for 8 columns.
    function automatic int unsigned shiftrows_offset(input int unsigned nb, input int unsigned row);
        int unsigned off;
        off = row;
        if (nb == 8 && row >= 2) off = row + 1;
        return off;
    endfunction

    // Source column is (col - offset) mod nb, formed as col + nb - offset so it never goes negative.
    function automatic int unsigned inv_shiftrows_addr(input int unsigned nb, input int unsigned row,
                                                       input int unsigned col);
        int unsigned src;
        src = col + nb - shiftrows_offset(nb, row);
        if (src >= nb) src = src - nb;
        return 4 * src + row;
    endfunction

endpackage

// File: rtl/rijndael_inv_shiftrows_stream.sv
// Byte-serial InvShiftRows stage: ping-pong state banks, one byte per cycle in
// and out over valid/ready, column-major byte order on both ports.
module rijndael_inv_shiftrows_stream
    import rijndael_pkg::*;
#(
    parameter int NB = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_byte,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_byte,
    output logic       out_valid,
    input  logic       out_ready
);

    localparam int STATE_BYTES = 4 * NB;
    localparam int ADDR_W      = $clog2(STATE_BYTES);
    localparam int COL_W       = $clog2(NB);

    if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
        $error("rijndael_inv_shiftrows_stream: NB must be 4, 6 or 8");
    end

    byte_t              bank [2][STATE_BYTES];
    logic [1:0]         full;
    logic               wr_bank;
    logic               rd_bank;
    logic [ADDR_W-1:0]  wr_cnt;
    logic [COL_W-1:0]   rd_col;
    logic [1:0]         rd_row;
    logic [ADDR_W-1:0]  rd_addr;
    logic               wr_fire;
    logic               wr_last;
    logic               rd_fire;
    logic               rd_last;

    // Handshake outputs depend on registered state only.
    assign in_ready  = !full[wr_bank];
    assign out_valid = full[rd_bank];

    assign wr_fire = in_valid && in_ready;
    assign wr_last = (wr_cnt == ADDR_W'(STATE_BYTES - 1));
    assign rd_fire = out_valid && out_ready;
    assign rd_last = (rd_col == COL_W'(NB - 1)) && (rd_row == 2'd3);

    assign rd_addr  = ADDR_W'(inv_shiftrows_addr(NB, 32'(rd_row), 32'(rd_col)));
    assign out_byte = out_valid ? bank[rd_bank][rd_addr] : 8'h00;

    // NOTE: bank storage carries no reset; the full flags alone decide what is valid,
    // so stale bytes are never observed and the array maps onto plain registers/RAM.
    always_ff @(posedge clk) begin
        if (wr_fire) bank[wr_bank][wr_cnt] <= in_byte;
    end

    // Write-complete and read-complete always target different banks, so both
    // flag updates can land on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            full    <= 2'b00;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_cnt  <= '0;
            rd_col  <= '0;
            rd_row  <= 2'd0;
        end else begin
            if (wr_fire) begin
                if (wr_last) begin
                    full[wr_bank] <= 1'b1;
                    wr_cnt        <= '0;
                    wr_bank       <= !wr_bank;
                end else begin
                    wr_cnt <= wr_cnt + 1'b1;
                end
            end
            if (rd_fire) begin
                rd_row <= rd_row + 2'd1;
                if (rd_row == 2'd3) begin
                    if (rd_last) begin
                        full[rd_bank] <= 1'b0;
                        rd_col        <= '0;
                        rd_bank       <= !rd_bank;
                    end else begin
                        rd_col <= rd_col + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: doc/rijndael_inv_shiftrows_stream.md
# rijndael_inv_shiftrows_stream

Byte-serial InvShiftRows stage for the Rijndael decryption datapath. Accepts one state byte per cycle in flattened column-major order over a valid/ready handshake. Emits the inverse-row-shifted state in the same byte order. Two state banks (ping-pong) sustain one byte per cycle with full backpressure. It is the inverse counterpart of the combinational forward ShiftRows stage and sits between the byte-serial InvSubBytes and AddRoundKey stages.

## Interface

- NB, 4, state columns; legal values 4, 6, 8; any other value is an elaboration error
- STATE_BYTES, 4*NB (localparam), bytes per state
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_byte  in  8  input state byte
- in_valid  in  1  in_byte valid
- in_ready  out  1  stage can accept in_byte this cycle
- out_byte  out  8  output state byte
- out_valid  out  1  out_byte valid
- out_ready  in  1  downstream accepts out_byte this cycle

## Operation

- Byte order, both ports: index k = 4*c + r (row r, column c). k=0 corresponds to bits [STATESIZE-1 -: 8] of the flattened state.
- Row offsets SHIFT[r]: {0,1,2,3} for NB=4 or 6; {0,1,3,4} for NB=8.
- Inverse mapping: out[r][c] = in[r][(c - SHIFT[r] + NB) mod NB]. Read address = 4*((c - SHIFT[r] + NB) mod NB) + r. All arithmetic uses unsigned counters; never form a negative index.
- Storage: two banks of STATE_BYTES bytes each. Per-bank flag full[b].
- Write side:
  - wr_bank (1 bit), wr_cnt (0..STATE_BYTES-1).
  - in_ready = !full[wr_bank].
  - On accept (in_valid & in_ready): write byte to bank[wr_bank][wr_cnt].
  - If wr_cnt = STATE_BYTES-1: set full[wr_bank], wr_cnt wraps to 0, toggle wr_bank. Otherwise increment wr_cnt.
- Read side:
  - rd_bank, rd_col (0..NB-1), rd_row (0..3); row is the inner loop.
  - out_valid = full[rd_bank].
  - out_byte = bank[rd_bank][read address] when out_valid, else 8'h00.
  - On transfer (out_valid & out_ready): advance rd_row. On row 3, advance rd_col.
  - At (rd_col=NB-1, rd_row=3): clear full[rd_bank], wrap both counters, toggle rd_bank.
- Simultaneous events:
  - Write-complete and read-complete in the same cycle touch different banks. Both take effect.
  - A bank may be set full and another cleared in the same edge.
- Holding: out_byte and out_valid stay stable while out_valid & !out_ready. in_byte is ignored when !in_ready.
- No partial-state flush. Only rst discards a partially written bank.

## Timing

- Reset (rst high at an edge): full[1:0]=0, wr_bank=rd_bank=0, all counters 0.
  - Outputs after reset: in_ready=1, out_valid=0, out_byte=8'h00.
  - Bank contents are not reset.
- rst mid-operation discards all buffered and partial states. The state above is reached at the next edge regardless of in_valid/out_ready.
- Latency: last byte of a state accepted at edge T → out_valid=1 in the cycle after T. The first output byte transfers at edge T+1 at the earliest.
- Throughput: one byte/cycle sustained with out_ready tied high. in_ready never drops in that case.
- Capacity: two full states. With out_ready=0, in_ready falls after 2*STATE_BYTES accepted bytes.
- in_ready and out_valid are functions of registers only. There is no combinational path from in_valid or out_ready to either.

## Structure

- Shared package rijndael_pkg holds:
  - function shiftrows_offset(nb, row) returning the SHIFT table. The forward stage uses the same function.
  - function inv_shiftrows_addr(nb, row, col) returning the read address.
  - state-byte typedef byte_t.
- No sub-module. Banks are a 2×STATE_BYTES register array inside the block; the address function comes from the package.

## Test plan

- NB=4, bytes 0x00..0x0F, out_ready=1 → output 00 0D 0A 07 04 01 0E 0B 08 05 02 0F 0C 09 06 03. out_valid first high the cycle after byte 0x0F is accepted.
- NB=6, bytes 0x00..0x17 → first column 00 15 12 0F; NB=8, bytes 0x00..0x1F → first column 00 1D 16 13. Full sequences are checked against a reference model.
- Round trip: random states pass through the forward ShiftRows stage and then this block, for NB=4, 6, 8. Output equals the original state for 1000 states.
- Backpressure, NB=4: out_ready=0 and in_valid=1 → in_ready=0 after exactly 32 accepts. After out_ready=1 both states drain in order, with no loss or duplication.
- Random in_valid/out_ready toggling for 500 states → in-order, bit-exact output. out_byte is stable while stalled.
- rst asserted after 7 of 16 bytes (NB=4) and while a full bank is draining → next cycle out_valid=0, in_ready=1, out_byte=00. The following state is processed correctly from byte 0.
